nf10_axis_capture_buf: RTL

Parametrised AXI4-Stream capture sink for NetFPGA-10G datapaths: it terminates one output-queue or DMA stream and stores every accepted beat in an internal ring buffer. Captured beats are read back through a first-word-fall-through (FWFT) read port, and packet and drop counters run alongside. Two flow-control modes are selectable: drop-on-full, for a passive tap, or backpressure, for a lossless sink. It is synthesizable and replaces file-based recorders wherever capture must run in hardware or under mixed simulation.

---
 rtl/nf10_axis_capture_buf.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/nf10_axis_capture_buf.sv
// rtl/nf10_axis_capture_buf.sv - AXI4-Stream capture sink with FWFT ring-buffer readback and counters
// Optional per-beat timestamping: define NF10_AXIS_CAPTURE_TSTAMP_EN.
module nf10_axis_capture_buf #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEPTH              = 512,
  parameter int C_BACKPRESSURE       = 0,
  parameter int C_TSTAMP_WIDTH       = 32
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic                              clear,
  input  logic                              rd_en,
  output logic                              rd_valid,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    rd_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  rd_tstrb,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   rd_tuser,
  output logic                              rd_tlast,
`ifdef NF10_AXIS_CAPTURE_TSTAMP_EN
  output logic [C_TSTAMP_WIDTH-1:0]         rd_tstamp,
`endif
  output logic [$clog2(C_DEPTH):0]          level,
  output logic [31:0]                       pkt_count,
  output logic [31:0]                       drop_count,
  output logic                              overflow
);

  localparam int AW = $clog2(C_DEPTH);
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam logic [AW:0] FullLvl = (AW+1)'(C_DEPTH);

  typedef enum logic {ST_PASS, ST_DROP} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [31:0]     pkt_q, pkt_d, drop_q, drop_d;
  logic            ovf_q, ovf_d, tready_q, tready_d;
  logic            accept, full, pop, store;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  mem_data [C_DEPTH];
  logic [SW-1:0]                   mem_strb [C_DEPTH];
  logic [C_S_AXIS_TUSER_WIDTH-1:0] mem_user [C_DEPTH];
  logic                            mem_last [C_DEPTH];

  always_comb begin
    accept   = s_axis_tvalid && tready_q;
    // Full is judged on the pre-read level, so a same-cycle pop cannot rescue a beat.
    full     = (level_q == FullLvl);
    pop      = rd_en && (level_q != '0) && !clear;
    store    = 1'b0;
    state_d  = state_q;
    pkt_d    = pkt_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (clear) begin
      state_d = ST_PASS;
      pkt_d   = '0;
      drop_d  = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      if (state_q == ST_DROP) begin
        if (s_axis_tlast) state_d = ST_PASS;
      end else if (full) begin
        if (drop_q != '1) drop_d = drop_q + 32'd1;
        ovf_d = 1'b1;
        if (!s_axis_tlast) state_d = ST_DROP;
      end else begin
        store = 1'b1;
        if (s_axis_tlast && (pkt_q != '1)) pkt_d = pkt_q + 32'd1;
      end
    end
    wr_ptr_d = clear ? '0 : wr_ptr_q + AW'(store);
    rd_ptr_d = clear ? '0 : rd_ptr_q + AW'(pop);
    level_d  = clear ? '0 : level_q + (AW+1)'(store) - (AW+1)'(pop);
    tready_d = (C_BACKPRESSURE != 0) ? (level_d < FullLvl) : 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_PASS;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      tready_q <= tready_d;
    end
  end

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge aclk) begin
    if (store) begin
      mem_data[wr_ptr_q] <= s_axis_tdata;
      mem_strb[wr_ptr_q] <= s_axis_tstrb;
      mem_user[wr_ptr_q] <= s_axis_tuser;
      mem_last[wr_ptr_q] <= s_axis_tlast;
    end
  end

`ifdef NF10_AXIS_CAPTURE_TSTAMP_EN
  logic [C_TSTAMP_WIDTH-1:0] tstamp_q;
  logic [C_TSTAMP_WIDTH-1:0] mem_ts [C_DEPTH];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) tstamp_q <= '0;
    else          tstamp_q <= tstamp_q + 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (store) mem_ts[wr_ptr_q] <= tstamp_q;
  end

  assign rd_tstamp = mem_ts[rd_ptr_q];
`else
  logic [C_TSTAMP_WIDTH-1:0] unused_tstamp;
  assign unused_tstamp = '0;
`endif

  assign s_axis_tready = tready_q;
  assign rd_valid      = (level_q != '0);
  assign rd_tdata      = mem_data[rd_ptr_q];
  assign rd_tstrb      = mem_strb[rd_ptr_q];
  assign rd_tuser      = mem_user[rd_ptr_q];
  assign rd_tlast      = mem_last[rd_ptr_q];
  assign level         = level_q;
  assign pkt_count     = pkt_q;
  assign drop_count    = drop_q;
  assign overflow      = ovf_q;

endmodule
